// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//
// 8N1 serial receiver: 1 start bit, 8 data bits LSB first, 1 stop bit.
// Bit timing is t_rate clock cycles per bit, matching the transmitter.
// Includes a line synchroniser, false-start rejection and framing-error
// detection.
//
// Optional feature (macro UART_RX_MAJORITY_EN):
//   defined     - every sample point takes a 2-of-3 majority of rx_s at
//                 mid-1, mid and mid+1; the decision is made at mid+1, so
//                 every sample and output pulse happens one cycle later.
//                 Needs t_rate >= 4.
//   not defined - a single sample of rx_s at mid.
//
// Ports:
//   clk        in   system clock
//   Rst_rx     in   asynchronous active-low reset
//   Rs232_rx   in   asynchronous serial line, idle high
//   data       out  [7:0] last correctly framed byte, held until next good frame
//   done       out  one-cycle pulse, data valid from this cycle
//   frame_err  out  one-cycle pulse, stop bit sampled low
//   busy       out  high while a frame is in progress (state != IDLE)
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int t_rate = 5208
) (
    input  logic       clk,
    input  logic       Rst_rx,
    input  logic       Rs232_rx,
    output logic [7:0] data,
    output logic       done,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ_DELAY = 1;
`else
    localparam int MAJ_DELAY = 0;
`endif

    // The START decision lands on the half-bit point (plus one cycle when
    // majority voting needs the mid+1 sample). Every later sample is then
    // exactly one full bit after the previous one.
    localparam logic [15:0] HALF_LAST = 16'(t_rate / 2 - 1 + MAJ_DELAY);
    localparam logic [15:0] BIT_LAST  = 16'(t_rate - 1);

    state_t      state;
    logic [15:0] baud_cnt;
    logic [3:0]  bit_cnt;
    logic [7:0]  shift;

    logic sync_1;
    logic rx_s;
    logic rx_d;
    logic fall;
    logic sample;

`ifdef UART_RX_MAJORITY_EN
    logic rx_d2;
`endif

    // Two-flop synchroniser (sync_1 -> rx_s) plus a history flop (rx_d).
    // All reset to the idle-high level so reset never fakes a start edge.
    always_ff @(posedge clk or negedge Rst_rx) begin
        if (!Rst_rx) begin
            sync_1 <= 1'b1;
            rx_s   <= 1'b1;
            rx_d   <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
            rx_d2  <= 1'b1;
`endif
        end else begin
            sync_1 <= Rs232_rx;
            rx_s   <= sync_1;
            rx_d   <= rx_s;
`ifdef UART_RX_MAJORITY_EN
            rx_d2  <= rx_d;
`endif
        end
    end

    // Only a high-to-low transition starts a frame; a line stuck low
    // produces no edge and therefore never restarts reception.
    assign fall = rx_d & ~rx_s;

`ifdef UART_RX_MAJORITY_EN
    // At mid+1: rx_s is mid+1, rx_d is mid, rx_d2 is mid-1.
    assign sample = (rx_s & rx_d) | (rx_s & rx_d2) | (rx_d & rx_d2);
`else
    assign sample = rx_s;
`endif

    always_ff @(posedge clk or negedge Rst_rx) begin
        if (!Rst_rx) begin
            state     <= IDLE;
            baud_cnt  <= 16'd0;
            bit_cnt   <= 4'd0;
            shift     <= 8'd0;
            data      <= 8'd0;
            done      <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            done      <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    baud_cnt <= 16'd0;
                    bit_cnt  <= 4'd0;
                    if (fall) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end

                // A line that is high again at mid start bit was a glitch.
                START: begin
                    if (baud_cnt == HALF_LAST) begin
                        baud_cnt <= 16'd0;
                        if (sample) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end

                DATA: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt <= 16'd0;
                        shift    <= {sample, shift[7:1]};
                        if (bit_cnt == 4'd7) begin
                            bit_cnt <= 4'd0;
                            state   <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end

                // Leaving at mid stop bit gives half a bit of slack to
                // catch a back-to-back start edge.
                STOP: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt <= 16'd0;
                        state    <= IDLE;
                        busy     <= 1'b0;
                        if (sample) begin
                            data <= shift;
                            done <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
//
// Directed bench for uart_rx with t_rate = 16. A transmitter model drives
// frames onto the line and pushes the expected outcome (byte or framing
// error, plus the cycle the pulse must appear in) onto a scoreboard; a
// monitor pops and compares whenever done or frame_err pulses.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int T_RATE = 16;

`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif

    // Line-drive cycle to pulse cycle: 2 synchroniser cycles, half bit,
    // nine full bits, one register cycle.
    localparam int PULSE_LAT = 2 + T_RATE / 2 + 9 * T_RATE + 1 + MAJ;

    logic       clk;
    logic       Rst_rx;
    logic       Rs232_rx;
    logic [7:0] data;
    logic       done;
    logic       frame_err;
    logic       busy;

    typedef struct {
        logic       err;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    int         cyc = 0;
    int         passed = 0;
    int         total = 0;
    logic [7:0] last_good = 8'h00;

    uart_rx #(.t_rate(T_RATE)) dut (
        .clk       (clk),
        .Rst_rx    (Rst_rx),
        .Rs232_rx  (Rs232_rx),
        .data      (data),
        .done      (done),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Transmitter model. Starts on a negedge, holds each level T_RATE
    // cycles and returns on the last negedge of the stop bit so the next
    // call starts the following frame with no gap. glitch_bit >= 0 inverts
    // that data bit for one cycle exactly at its receiver mid-point.
    task automatic send_frame(input logic [7:0] b, input logic stop_val,
                              input int glitch_bit, input bit chk_busy);
        logic [9:0] lv;
        logic [7:0] exp_byte;
        int         c;
        exp_t       e;
        lv = {stop_val, b, 1'b0};
        exp_byte = b;
        if (glitch_bit >= 0 && MAJ == 0)
            exp_byte[glitch_bit] = ~exp_byte[glitch_bit];
        @(negedge clk);
        c = cyc;
        e.err  = ~stop_val;
        e.data = exp_byte;
        e.cyc  = c + PULSE_LAT;
        sb.push_back(e);
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < T_RATE; j++) begin
                if (!(k == 0 && j == 0)) @(negedge clk);
                if (glitch_bit >= 0 && k == glitch_bit + 1 && j == T_RATE / 2)
                    Rs232_rx = ~lv[k];
                else
                    Rs232_rx = lv[k];
                if (chk_busy && k == 0 && j == 2) check("busy_at_T0", busy, 1'b0);
                if (chk_busy && k == 0 && j == 3) check("busy_after_T0", busy, 1'b1);
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            Rs232_rx = 1'b1;
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (done || frame_err) begin
            check("pulse_exclusive", done & frame_err, 1'b0);
            if (sb.size() == 0) begin
                check("unexpected_pulse", {done, frame_err}, 2'b00);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_kind_err", frame_err, e.err);
                check("pulse_cycle", cyc, e.cyc);
                if (e.err) begin
                    check("data_held_on_err", data, last_good);
                end else begin
                    check("rx_data", data, e.data);
                    last_good = e.data;
                end
            end
        end
    end

    initial begin
        int c;
        Rst_rx   = 1'b0;
        Rs232_rx = 1'b1;

        // Reset and idle line
        repeat (3) @(negedge clk);
        check("rst_data", data, 8'h00);
        check("rst_busy", busy, 1'b0);
        Rst_rx = 1'b1;
        idle_cycles(100);
        check("idle_data", data, 8'h00);
        check("idle_done", done, 1'b0);
        check("idle_frame_err", frame_err, 1'b0);
        check("idle_busy", busy, 1'b0);

        // Single clean frame with busy timing
        send_frame(8'hA5, 1'b1, -1, 1'b1);
        idle_cycles(20);
        check("a5_busy_after", busy, 1'b0);

        // Back-to-back frames
        send_frame(8'h00, 1'b1, -1, 1'b0);
        send_frame(8'hFF, 1'b1, -1, 1'b0);
        send_frame(8'h3C, 1'b1, -1, 1'b0);
        idle_cycles(20);
        check("b2b_all_seen", sb.size(), 0);

        // Short low glitch on an idle line
        @(negedge clk);
        c = cyc;
        Rs232_rx = 1'b0;
        for (int n = 1; n < 16; n++) begin
            @(negedge clk);
            if (n == 5) Rs232_rx = 1'b1;
            if (n == 10) check("glitch_busy_before_abort", busy, 1'b1);
            if (n == 11) check("glitch_busy_after_abort", busy, 1'b0);
        end
        idle_cycles(30);
        check("glitch_data", data, 8'h3C);

        // Framing error with the line held low afterwards
        send_frame(8'h55, 1'b0, -1, 1'b0);
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            Rs232_rx = 1'b0;
        end
        check("low_line_busy", busy, 1'b0);
        check("low_line_err_seen", sb.size(), 0);
        idle_cycles(30);
        check("after_low_busy", busy, 1'b0);
        check("after_err_data", data, 8'h3C);

        // Reset during data bit 4 of 0x81, transmitter aborts too
        @(negedge clk);
        c = cyc;
        Rs232_rx = 1'b0;
        for (int n = 1; n < 85; n++) begin
            logic [9:0] lv;
            lv = {1'b1, 8'h81, 1'b0};
            @(negedge clk);
            Rs232_rx = lv[n / T_RATE];
        end
        check("pre_reset_busy", busy, 1'b1);
        @(negedge clk);
        Rst_rx   = 1'b0;
        Rs232_rx = 1'b1;
        #1;
        check("midrst_data", data, 8'h00);
        check("midrst_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        Rst_rx = 1'b1;
        last_good = 8'h00;
        idle_cycles(40);
        check("postrst_data", data, 8'h00);
        check("postrst_busy", busy, 1'b0);
        send_frame(8'h42, 1'b1, -1, 1'b0);
        idle_cycles(20);

        // One-cycle glitch at the mid-point of bit 2 of 0xF0
        send_frame(8'hF0, 1'b1, 2, 1'b0);
        idle_cycles(30);

        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
